// File: rtl/am_interval_timer_pkg.sv
// Shared encodings for the interval timer: controller states and timer modes.
package am_interval_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int unsigned STAGE_W = 4;

endpackage

// File: rtl/am_timer_stage.sv
// 4-bit synchronous up-counter stage with active-low sync clear/load and P/T enables.
module am_timer_stage
    import am_interval_timer_pkg::*;
(
    input  logic               cp,
    input  logic [STAGE_W-1:0] din,
    input  logic               p,
    input  logic               t,
    input  logic               load_,
    input  logic               clr_,
    output logic [STAGE_W-1:0] q,
    output logic               co
);

    always_ff @(posedge cp) begin
        if (!clr_) begin
            q <= '0;
        end else if (!load_) begin
            q <= din;
        end else if (p && t) begin
            q <= q + 1'b1;
        end
    end

    // Carry-out depends on T, not P, so it ripples through the chain regardless of gating.
    assign co = t & (&q);

endmodule

// File: rtl/am_interval_timer.sv
// Programmable interval timer: cascaded 4-bit stages sequenced by a two-state controller.
module am_interval_timer
    import am_interval_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             cp,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] preset,
    input  logic             gate,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    localparam int unsigned NumStages = WIDTH / STAGE_W;

    state_e           state_q, state_d;
    logic             mode_q;
    logic [WIDTH-1:0] reload_q;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    logic             load;
    logic             capture;
    logic             cnt_en;
    logic             term;
    logic [WIDTH-1:0] din;

    logic [NumStages:0]   t_chain;
    logic [NumStages-1:0] co;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        cnt_en  = 1'b0;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    capture = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (gate && term) begin
                    tick_d = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        load = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (gate) begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Terminal handling replaces the increment, so the chain never wraps past all ones.
    assign din = (state_q == ST_IDLE) ? preset : reload_q;

    always_ff @(posedge cp) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ONESHOT;
            reload_q <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            if (capture) begin
                reload_q <= preset;
                mode_q   <= mode;
            end
        end
    end

    assign t_chain[0] = 1'b1;

    for (genvar k = 0; k < NumStages; k++) begin : g_stage
        am_timer_stage u_stage (
            .cp    (cp),
            .din   (din[k*STAGE_W +: STAGE_W]),
            .p     (cnt_en),
            .t     (t_chain[k]),
            .load_ (~load),
            .clr_  (~clr),
            .q     (q[k*STAGE_W +: STAGE_W]),
            .co    (co[k])
        );
        assign t_chain[k+1] = co[k];
    end

    assign term = t_chain[NumStages];
    assign busy = (state_q == ST_RUN);
    assign tick = tick_q;
    assign done = done_q;

endmodule

// File: tb/tb_am_interval_timer.sv
// Directed self-checking bench for am_interval_timer at WIDTH=8.
module tb_am_interval_timer;

    logic       cp = 1'b0;
    logic       clr, start, stop, mode, gate;
    logic [7:0] preset;
    logic [7:0] q;
    logic       busy, tick, done;

    int checks = 0;
    int errors = 0;

    logic [7:0] p_q    [6] = '{8'hFE, 8'hFF, 8'hFD, 8'hFE, 8'hFF, 8'hFD};
    logic       p_tick [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       g_gate [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] g_q    [6] = '{8'hFD, 8'hFD, 8'hFD, 8'hFE, 8'hFF, 8'hFC};
    logic       g_tick [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    am_interval_timer #(.WIDTH(8)) dut (
        .cp     (cp),
        .clr    (clr),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .preset (preset),
        .gate   (gate),
        .q      (q),
        .busy   (busy),
        .tick   (tick),
        .done   (done)
    );

    always #5 cp = ~cp;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 1'b0; start = 1'b0; stop = 1'b0; gate = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b1; mode = 1'b1; preset = 8'hAA; gate = 1'b1; stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (q !== 8'h00 || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: q=%h busy=%b tick=%b done=%b, need q=00 busy=0 tick=0 done=0",
                         i, q, busy, tick, done);
            end
        end
        idle_inputs();
    endtask

    task automatic test_periodic();
        start = 1'b1; mode = 1'b1; preset = 8'hFD; gate = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (q !== 8'hFD || busy !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL periodic_start: q=%h busy=%b tick=%b, need q=fd busy=1 tick=0", q, busy, tick);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (q !== p_q[i] || tick !== p_tick[i] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL periodic[%0d]: q=%h tick=%b busy=%b done=%b, need q=%h tick=%b busy=1 done=0",
                         i, q, tick, busy, done, p_q[i], p_tick[i]);
            end
        end
        stop = 1'b1; gate = 1'b0;
        step();
        idle_inputs();
        checks++;
        if (busy !== 1'b0 || q !== 8'hFD) begin
            errors++;
            $display("FAIL periodic_stop: busy=%b q=%h, need busy=0 q=fd", busy, q);
        end
    endtask

    task automatic test_oneshot();
        start = 1'b1; mode = 1'b0; preset = 8'hFE; gate = 1'b1;
        step();
        start = 1'b0;
        mode = 1'b1;  // changes after start must not matter
        checks++;
        if (q !== 8'hFE || busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_start: q=%h busy=%b, need q=fe busy=1", q, busy);
        end
        step();
        checks++;
        if (q !== 8'hFF || tick !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_ff: q=%h tick=%b done=%b busy=%b, need q=ff tick=0 done=0 busy=1",
                     q, tick, done, busy);
        end
        step();
        checks++;
        if (q !== 8'hFF || tick !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_done: q=%h tick=%b done=%b busy=%b, need q=ff tick=1 done=1 busy=0",
                     q, tick, done, busy);
        end
        step();
        checks++;
        if (q !== 8'hFF || tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_hold: q=%h tick=%b done=%b busy=%b, need q=ff tick=0 done=0 busy=0",
                     q, tick, done, busy);
        end
        start = 1'b1; stop = 1'b1; mode = 1'b0; preset = 8'hF0;
        step();
        idle_inputs();
        checks++;
        if (q !== 8'hF0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_restart: q=%h busy=%b, need q=f0 busy=1", q, busy);
        end
        stop = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_gate();
        start = 1'b1; mode = 1'b1; preset = 8'hFC;
        step();
        start = 1'b0;
        checks++;
        if (q !== 8'hFC || busy !== 1'b1) begin
            errors++;
            $display("FAIL gate_start: q=%h busy=%b, need q=fc busy=1", q, busy);
        end
        for (int i = 0; i < 6; i++) begin
            gate = g_gate[i];
            step();
            checks++;
            if (q !== g_q[i] || tick !== g_tick[i]) begin
                errors++;
                $display("FAIL gate[%0d]: q=%h tick=%b, need q=%h tick=%b", i, q, tick, g_q[i], g_tick[i]);
            end
        end
        gate = 1'b1;
        step();
        step();
        step();
        gate = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (q !== 8'hFF || tick !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL gate_hold_ff[%0d]: q=%h tick=%b busy=%b, need q=ff tick=0 busy=1",
                         i, q, tick, busy);
            end
        end
        stop = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_stop_priority();
        start = 1'b1; mode = 1'b1; preset = 8'hFE;
        step();
        start = 1'b1; preset = 8'h00; gate = 1'b0;
        step();
        checks++;
        if (q !== 8'hFE || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: q=%h busy=%b, need q=fe busy=1", q, busy);
        end
        start = 1'b0; gate = 1'b1;
        step();
        checks++;
        if (q !== 8'hFF) begin
            errors++;
            $display("FAIL stop_setup: q=%h, need q=ff", q);
        end
        stop = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (q !== 8'hFF || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL stop_at_ff: q=%h busy=%b tick=%b done=%b, need q=ff busy=0 tick=0 done=0",
                     q, busy, tick, done);
        end
        step();
        checks++;
        if (q !== 8'hFF || busy !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: q=%h busy=%b tick=%b, need q=ff busy=0 tick=0", q, busy, tick);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; mode = 1'b1; preset = 8'hFF; gate = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (q !== 8'hFF || tick !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: q=%h tick=%b busy=%b, need q=ff tick=0 busy=1", q, tick, busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (q !== 8'hFF || tick !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d]: q=%h tick=%b busy=%b done=%b, need q=ff tick=1 busy=1 done=0",
                         i, q, tick, busy, done);
            end
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clr_mid_run: q=%h busy=%b tick=%b done=%b, need q=00 busy=0 tick=0 done=0",
                     q, busy, tick, done);
        end
        step();
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL clr_after: q=%h busy=%b tick=%b, need q=00 busy=0 tick=0", q, busy, tick);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        mode = 1'b0;
        preset = 8'h00;
        #2;
        test_reset();
        test_periodic();
        test_oneshot();
        test_gate();
        test_stop_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
